// File: rtl/core_pkg.sv
// ============================================================================
//  Module      : core_pkg
//  Description : Shared definitions for the scalar in-order LoongArch core:
//                pipeline bus widths, EXE-to-MEM bus layout, load-op bit
//                indices and exception codes consumed by WB.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package core_pkg;

    // Pipeline bus widths
    localparam int EXE_TO_MEM_BUS_W = 77;
    localparam int MEM_TO_WB_BUS_W  = 71;
    localparam int MEM_FWD_BUS_W    = 39;

    // Load-op one-hot bit indices inside ld_op[4:0] = {w, h, hu, b, bu}
    localparam int LD_OP_W  = 5;
    localparam int LD_W_IDX  = 4;
    localparam int LD_H_IDX  = 3;
    localparam int LD_HU_IDX = 2;
    localparam int LD_B_IDX  = 1;
    localparam int LD_BU_IDX = 0;

    // Exception codes (Ecode field of ESTAT) already used by WB
    localparam logic [5:0] ECODE_INT = 6'h00;
    localparam logic [5:0] ECODE_ADE = 6'h08;
    localparam logic [5:0] ECODE_ALE = 6'h09;
    localparam logic [5:0] ECODE_SYS = 6'h0B;
    localparam logic [5:0] ECODE_BRK = 6'h0C;
    localparam logic [5:0] ECODE_INE = 6'h0D;

    // EXE-to-MEM bus, MSB first
    typedef struct packed {
        logic                ex;
        logic                req_issued;
        logic [LD_OP_W-1:0]  ld_op;
        logic [31:0]         alu_result;
        logic                gr_we;
        logic [4:0]          dest;
        logic [31:0]         pc;
    } exe_to_mem_t;

    // True when the instruction is any kind of load
    function automatic logic is_load(input logic [LD_OP_W-1:0] ld_op);
        return |ld_op;
    endfunction

endpackage

`default_nettype wire

// File: rtl/load_align.sv
// ============================================================================
//  Module      : load_align
//  Description : Combinational load-data aligner. Selects the addressed byte
//                or halfword of the response word and sign/zero-extends it.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module load_align
    import core_pkg::*;
(
    input  logic [LD_OP_W-1:0] i_ld_op,
    input  logic [1:0]         i_offset,
    input  logic [31:0]        i_rdata,
    output logic [31:0]        o_result
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Pick the addressed byte/halfword, then extend according to the load type
    always_comb begin
        w_byte   = 8'h00;
        w_half   = i_offset[1] ? i_rdata[31:16] : i_rdata[15:0];
        o_result = i_rdata;
        case (i_offset)
            2'd0:    w_byte = i_rdata[7:0];
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            default: w_byte = i_rdata[31:24];
        endcase
        if (i_ld_op[LD_B_IDX]) begin
            o_result = {{24{w_byte[7]}}, w_byte};
        end else if (i_ld_op[LD_BU_IDX]) begin
            o_result = {24'h000000, w_byte};
        end else if (i_ld_op[LD_H_IDX]) begin
            o_result = {{16{w_half[15]}}, w_half};
        end else if (i_ld_op[LD_HU_IDX]) begin
            o_result = {16'h0000, w_half};
        end
    end

endmodule

`default_nettype wire

// File: rtl/mem_stage.sv
// ============================================================================
//  Module      : mem_stage
//  Description : MEM pipeline stage. Waits for data-SRAM responses of requests
//                issued in EXE, buffers them under WB back-pressure, aligns
//                load data, drives the MEM-to-WB and forwarding buses, and
//                drops responses that belong to instructions killed by a flush.
//  Options     : MEM_PERF_CNT_EN adds perf_mem_stall_cnt (stall-cycle count).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_stage
    import core_pkg::*;
#(
    parameter int DISCARD_CNT_W = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        exec_flush,
    input  logic                        exe_to_mem_valid,
    input  logic [EXE_TO_MEM_BUS_W-1:0] exe_to_mem_bus,
    input  logic                        exe_req_inflight,
    output logic                        mem_allowin,
    input  logic                        wb_allowin,
    output logic                        mem_to_wb_valid,
    output logic [MEM_TO_WB_BUS_W-1:0]  mem_to_wb_bus,
    output logic [MEM_FWD_BUS_W-1:0]    mem_fwd_bus,
    input  logic                        data_sram_data_ok,
    input  logic [31:0]                 data_sram_rdata
`ifdef MEM_PERF_CNT_EN
    ,
    output logic [31:0]                 perf_mem_stall_cnt
`endif
);

    localparam logic [DISCARD_CNT_W-1:0] c_CNT_MAX      = {DISCARD_CNT_W{1'b1}};
    localparam logic [DISCARD_CNT_W:0]   c_CNT_MAX_WIDE = {1'b0, {DISCARD_CNT_W{1'b1}}};

    logic                     r_valid;
    exe_to_mem_t              r_bus;
    logic                     r_buf_valid;
    logic [31:0]              r_buf_data;
    logic [DISCARD_CNT_W-1:0] r_discard_cnt;

    logic                     w_ok_counted;
    logic                     w_ready_go;
    logic                     w_allowin;
    logic                     w_accept;
    logic                     w_handoff;
    logic                     w_waiting;
    logic                     w_capture;
    logic                     w_inc_kill;
    logic                     w_inc_exe;
    logic                     w_dec;
    logic [DISCARD_CNT_W:0]   w_cnt_sum;
    logic                     w_cnt_sat;
    logic [31:0]              w_rdata_sel;
    logic [31:0]              w_aligned;
    logic [31:0]              w_final;
    logic                     w_block;

    // Handshake and state decode; a data_ok only counts when nothing is left to drop
    always_comb begin
        w_ok_counted = data_sram_data_ok & (r_discard_cnt == '0);
        w_ready_go   = !r_bus.req_issued | r_buf_valid | w_ok_counted;
        w_allowin    = !r_valid | (w_ready_go & wb_allowin);
        w_accept     = exe_to_mem_valid & w_allowin;
        w_handoff    = r_valid & w_ready_go & wb_allowin;
        w_waiting    = r_valid & r_bus.req_issued & !r_buf_valid;
        w_capture    = w_waiting & w_ok_counted & !wb_allowin;
    end

    // Discard-counter arithmetic. A killed waiting instruction still owes a
    // response unless this very cycle's data_ok was the counted one for it.
    always_comb begin
        w_inc_kill = exec_flush & w_waiting & !w_ok_counted;
        w_inc_exe  = exec_flush & exe_req_inflight;
        w_dec      = data_sram_data_ok & (r_discard_cnt != '0);
        w_cnt_sum  = {1'b0, r_discard_cnt}
                   + {{DISCARD_CNT_W{1'b0}}, w_inc_kill}
                   + {{DISCARD_CNT_W{1'b0}}, w_inc_exe}
                   - {{DISCARD_CNT_W{1'b0}}, w_dec};
        w_cnt_sat  = (w_cnt_sum > c_CNT_MAX_WIDE);
    end

    // Stage valid: flush kills, otherwise refill whenever MEM can accept
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid <= 1'b0;
        end else if (exec_flush) begin
            r_valid <= 1'b0;
        end else if (w_allowin) begin
            r_valid <= exe_to_mem_valid;
        end
    end

    // Instruction payload, loaded only on an accept that is not flushed
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_bus <= '0;
        end else if (w_accept && !exec_flush) begin
            r_bus <= exe_to_mem_t'(exe_to_mem_bus);
        end
    end

    // Response buffer holds load data while WB is back-pressuring
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_buf_valid <= 1'b0;
            r_buf_data  <= 32'h0;
        end else if (exec_flush || w_handoff) begin
            r_buf_valid <= 1'b0;
        end else if (w_capture) begin
            r_buf_valid <= 1'b1;
            r_buf_data  <= data_sram_rdata;
        end
    end

    // Count of responses still owed to killed instructions, saturating
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_discard_cnt <= '0;
        end else if (w_cnt_sat) begin
            r_discard_cnt <= c_CNT_MAX;
        end else begin
            r_discard_cnt <= w_cnt_sum[DISCARD_CNT_W-1:0];
        end
    end

    // Overflowing the discard counter means more requests are in flight than it can track
    a_discard_no_sat : assert property (@(posedge clk) disable iff (reset) !w_cnt_sat);

    load_align u_load_align (
        .i_ld_op    (r_bus.ld_op),
        .i_offset   (r_bus.alu_result[1:0]),
        .i_rdata    (w_rdata_sel),
        .o_result   (w_aligned)
    );

    // Result selection and output buses
    always_comb begin
        w_rdata_sel = r_buf_valid ? r_buf_data : data_sram_rdata;
        w_final     = is_load(r_bus.ld_op) ? w_aligned : r_bus.alu_result;
        w_block     = r_valid & is_load(r_bus.ld_op) & !w_ready_go;
    end

    assign mem_allowin     = w_allowin;
    assign mem_to_wb_valid = r_valid & w_ready_go;
    assign mem_to_wb_bus   = {r_bus.ex, w_final, r_bus.gr_we, r_bus.dest, r_bus.pc};
    assign mem_fwd_bus     = {w_block, r_valid & r_bus.gr_we, r_bus.dest, w_final};

`ifdef MEM_PERF_CNT_EN
    logic [31:0] r_perf_stall;

    // Cycles spent holding a valid instruction that cannot yet leave MEM
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_perf_stall <= 32'h0;
        end else if (r_valid && !w_ready_go) begin
            r_perf_stall <= r_perf_stall + 32'd1;
        end
    end

    assign perf_mem_stall_cnt = r_perf_stall;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mem_stage.sv
// ============================================================================
//  Module      : tb_mem_stage
//  Description : Self-checking bench for mem_stage: table of directed load/ALU
//                vectors plus hand-written back-pressure, flush and reset runs.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_stage;
    import core_pkg::*;

    localparam logic [4:0] c_LD_NONE = 5'b00000;
    localparam logic [4:0] c_LD_W    = 5'b10000;
    localparam logic [4:0] c_LD_H    = 5'b01000;
    localparam logic [4:0] c_LD_HU   = 5'b00100;
    localparam logic [4:0] c_LD_B    = 5'b00010;
    localparam logic [4:0] c_LD_BU   = 5'b00001;

    logic        clk;
    logic        reset;
    logic        exec_flush;
    logic        exe_to_mem_valid;
    logic [76:0] exe_to_mem_bus;
    logic        exe_req_inflight;
    logic        mem_allowin;
    logic        wb_allowin;
    logic        mem_to_wb_valid;
    logic [70:0] mem_to_wb_bus;
    logic [38:0] mem_fwd_bus;
    logic        data_sram_data_ok;
    logic [31:0] data_sram_rdata;
`ifdef MEM_PERF_CNT_EN
    logic [31:0] perf_mem_stall_cnt;
`endif

    int n_checks;
    int n_errors;
    int exp_stall;

    mem_stage #(.DISCARD_CNT_W(2)) dut (
        .clk               (clk),
        .reset             (reset),
        .exec_flush        (exec_flush),
        .exe_to_mem_valid  (exe_to_mem_valid),
        .exe_to_mem_bus    (exe_to_mem_bus),
        .exe_req_inflight  (exe_req_inflight),
        .mem_allowin       (mem_allowin),
        .wb_allowin        (wb_allowin),
        .mem_to_wb_valid   (mem_to_wb_valid),
        .mem_to_wb_bus     (mem_to_wb_bus),
        .mem_fwd_bus       (mem_fwd_bus),
        .data_sram_data_ok (data_sram_data_ok),
        .data_sram_rdata   (data_sram_rdata)
`ifdef MEM_PERF_CNT_EN
        ,
        .perf_mem_stall_cnt(perf_mem_stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  ld;
        logic        req;
        logic [31:0] alu;
        logic [31:0] rdata;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [70:0] act, input logic [70:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [76:0] mk(input logic ex, input logic req, input logic [4:0] ld,
                                       input logic [31:0] alu, input logic [4:0] dest);
        return {ex, req, ld, alu, 1'b1, dest, alu ^ 32'h1C00_0000};
    endfunction

    task automatic idle();
        exe_to_mem_valid  = 1'b0;
        exec_flush        = 1'b0;
        exe_req_inflight  = 1'b0;
        data_sram_data_ok = 1'b0;
        wb_allowin        = 1'b1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_perf(input string name);
`ifdef MEM_PERF_CNT_EN
        check(name, 71'(perf_mem_stall_cnt), 71'(exp_stall));
`else
        n_checks = n_checks + 0;
`endif
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        exp_stall = 0;

        vecs[0]  = '{c_LD_BU,   1'b1, 32'h0000_1003, 32'h80FF_1234, 32'h0000_0080};
        vecs[1]  = '{c_LD_B,    1'b1, 32'h0000_1003, 32'h80FF_1234, 32'hFFFF_FF80};
        vecs[2]  = '{c_LD_H,    1'b1, 32'h0000_2002, 32'h8001_0000, 32'hFFFF_8001};
        vecs[3]  = '{c_LD_HU,   1'b1, 32'h0000_2002, 32'h8001_0000, 32'h0000_8001};
        vecs[4]  = '{c_LD_W,    1'b1, 32'h0000_4000, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
        vecs[5]  = '{c_LD_B,    1'b1, 32'h0000_0011, 32'h80FF_1234, 32'h0000_0012};
        vecs[6]  = '{c_LD_B,    1'b1, 32'h0000_0012, 32'h80FF_1234, 32'hFFFF_FFFF};
        vecs[7]  = '{c_LD_BU,   1'b1, 32'h0000_0012, 32'h80FF_1234, 32'h0000_00FF};
        vecs[8]  = '{c_LD_H,    1'b1, 32'h0000_0010, 32'h80FF_1234, 32'h0000_1234};
        vecs[9]  = '{c_LD_H,    1'b1, 32'h0000_0000, 32'h0000_9ABC, 32'hFFFF_9ABC};
        vecs[10] = '{c_LD_NONE, 1'b0, 32'h1234_5678, 32'h5555_5555, 32'h1234_5678};
        vecs[11] = '{c_LD_NONE, 1'b1, 32'h0000_0ABC, 32'hFFFF_FFFF, 32'h0000_0ABC};

        // Reset state
        reset           = 1'b1;
        idle();
        exe_to_mem_bus  = '0;
        data_sram_rdata = '0;
        repeat (2) @(posedge clk);
        #4;
        check("reset_valid",   71'(mem_to_wb_valid), 71'(1'b0));
        check("reset_allowin", 71'(mem_allowin),     71'(1'b1));
        check("reset_fwd",     71'(mem_fwd_bus),     71'(0));
        check("reset_wbbus",   mem_to_wb_bus,        71'(0));
        check_perf("reset_perf");
        tick();
        reset = 1'b0;

        // Table-driven loads and ALU ops
        for (int i = 0; i < 12; i++) begin
            tick();
            idle();
            exe_to_mem_valid = 1'b1;
            exe_to_mem_bus   = mk(1'b0, vecs[i].req, vecs[i].ld, vecs[i].alu, 5'(i + 1));
            #3;
            check($sformatf("vec%0d_allowin", i), 71'(mem_allowin), 71'(1'b1));
            check($sformatf("vec%0d_empty", i), 71'(mem_to_wb_valid), 71'(1'b0));
            tick();
            idle();
            if (vecs[i].req) begin
                #3;
                check($sformatf("vec%0d_wait_valid", i), 71'(mem_to_wb_valid), 71'(1'b0));
                check($sformatf("vec%0d_wait_block", i), 71'(mem_fwd_bus[38]),
                      71'(vecs[i].ld != 5'b00000));
                exp_stall++;
                tick();
                idle();
                data_sram_data_ok = 1'b1;
                data_sram_rdata   = vecs[i].rdata;
            end else begin
                data_sram_rdata   = vecs[i].rdata;
            end
            #3;
            check($sformatf("vec%0d_valid", i), 71'(mem_to_wb_valid), 71'(1'b1));
            check($sformatf("vec%0d_final", i), 71'(mem_to_wb_bus[69:38]), 71'(vecs[i].exp));
            check($sformatf("vec%0d_dest", i), 71'(mem_to_wb_bus[36:32]), 71'(i + 1));
            check($sformatf("vec%0d_fwd", i), 71'(mem_fwd_bus[37:0]),
                  71'({1'b1, 5'(i + 1), vecs[i].exp}));
        end
        check_perf("vec_perf");

        // Back-to-back ALU ops: one per cycle, no stall
        tick();
        idle();
        exe_to_mem_valid = 1'b1;
        exe_to_mem_bus   = mk(1'b1, 1'b0, c_LD_NONE, 32'h0000_A000, 5'd20);
        for (int k = 1; k <= 4; k++) begin
            tick();
            idle();
            if (k < 4) begin
                exe_to_mem_valid = 1'b1;
                exe_to_mem_bus   = mk(1'b0, 1'b0, c_LD_NONE, 32'h0000_A000 + 32'(k), 5'(20 + k));
            end
            #3;
            check($sformatf("b2b%0d_valid", k), 71'(mem_to_wb_valid), 71'(1'b1));
            check($sformatf("b2b%0d_final", k), 71'(mem_to_wb_bus[69:38]),
                  71'(32'h0000_A000 + 32'(k - 1)));
            check($sformatf("b2b%0d_ex", k), 71'(mem_to_wb_bus[70]), 71'(k == 1));
            check($sformatf("b2b%0d_allowin", k), 71'(mem_allowin), 71'(1'b1));
        end
        tick();
        idle();
        #3;
        check("b2b_drain", 71'(mem_to_wb_valid), 71'(1'b0));
        check_perf("b2b_perf");

        // WB back-pressure: response buffered for three cycles
        tick();
        idle();
        exe_to_mem_valid = 1'b1;
        exe_to_mem_bus   = mk(1'b0, 1'b1, c_LD_W, 32'h0000_0100, 5'd9);
        tick();
        idle();
        wb_allowin        = 1'b0;
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'hCAFE_BABE;
        #3;
        check("bp0_valid",   71'(mem_to_wb_valid),      71'(1'b1));
        check("bp0_allowin", 71'(mem_allowin),          71'(1'b0));
        check("bp0_final",   71'(mem_to_wb_bus[69:38]), 71'(32'hCAFE_BABE));
        for (int k = 1; k <= 2; k++) begin
            tick();
            idle();
            wb_allowin      = 1'b0;
            data_sram_rdata = 32'h1111_1111;
            #3;
            check($sformatf("bp%0d_valid", k),   71'(mem_to_wb_valid),      71'(1'b1));
            check($sformatf("bp%0d_final", k),   71'(mem_to_wb_bus[69:38]), 71'(32'hCAFE_BABE));
            check($sformatf("bp%0d_allowin", k), 71'(mem_allowin),          71'(1'b0));
            check($sformatf("bp%0d_block", k),   71'(mem_fwd_bus[38]),      71'(1'b0));
        end
        tick();
        idle();
        data_sram_rdata = 32'h2222_2222;
        #3;
        check("bp_release_valid",   71'(mem_to_wb_valid),      71'(1'b1));
        check("bp_release_final",   71'(mem_to_wb_bus[69:38]), 71'(32'hCAFE_BABE));
        check("bp_release_allowin", 71'(mem_allowin),          71'(1'b1));
        tick();
        idle();
        #3;
        check("bp_drain", 71'(mem_to_wb_valid), 71'(1'b0));

        // Flush while waiting with a second request in flight: drop two responses
        tick();
        idle();
        exe_to_mem_valid = 1'b1;
        exe_to_mem_bus   = mk(1'b0, 1'b1, c_LD_BU, 32'h0000_1003, 5'd3);
        tick();
        idle();
        exec_flush       = 1'b1;
        exe_req_inflight = 1'b1;
        #3;
        check("fl_wait_block", 71'(mem_fwd_bus[38]), 71'(1'b1));
        exp_stall++;
        tick();
        idle();
        exe_to_mem_valid = 1'b1;
        exe_to_mem_bus   = mk(1'b0, 1'b1, c_LD_W, 32'h0000_0200, 5'd7);
        #3;
        check("fl_killed_valid", 71'(mem_to_wb_valid), 71'(1'b0));
        check("fl_allowin",      71'(mem_allowin),     71'(1'b1));
        tick();
        idle();
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'hAAAA_AAAA;
        #3;
        check("fl_drop1_valid", 71'(mem_to_wb_valid), 71'(1'b0));
        check("fl_drop1_block", 71'(mem_fwd_bus[38]), 71'(1'b1));
        exp_stall++;
        tick();
        idle();
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'hBBBB_BBBB;
        #3;
        check("fl_drop2_valid", 71'(mem_to_wb_valid), 71'(1'b0));
        exp_stall++;
        tick();
        idle();
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h1234_5678;
        #3;
        check("fl_own_valid", 71'(mem_to_wb_valid),      71'(1'b1));
        check("fl_own_final", 71'(mem_to_wb_bus[69:38]), 71'(32'h1234_5678));
        tick();
        idle();
        #3;
        check("fl_drain", 71'(mem_to_wb_valid), 71'(1'b0));

        // Flush beats a same-cycle accept
        tick();
        idle();
        exec_flush       = 1'b1;
        exe_to_mem_valid = 1'b1;
        exe_to_mem_bus   = mk(1'b0, 1'b0, c_LD_NONE, 32'h0000_0777, 5'd4);
        tick();
        idle();
        #3;
        check("flush_prio_valid", 71'(mem_to_wb_valid), 71'(1'b0));
        check_perf("flush_perf");

        // Reset during WAIT with one response pending discard
        tick();
        idle();
        exec_flush       = 1'b1;
        exe_req_inflight = 1'b1;
        tick();
        idle();
        exe_to_mem_valid = 1'b1;
        exe_to_mem_bus   = mk(1'b0, 1'b1, c_LD_W, 32'h0000_0300, 5'd5);
        tick();
        idle();
        #3;
        check("rst_pre_block", 71'(mem_fwd_bus[38]), 71'(1'b1));
        #1;
        reset = 1'b1;
        #1;
        exp_stall = 0;
        check("rst_mid_valid",   71'(mem_to_wb_valid), 71'(1'b0));
        check("rst_mid_allowin", 71'(mem_allowin),     71'(1'b1));
        check("rst_mid_fwd",     71'(mem_fwd_bus),     71'(0));
        check("rst_mid_wbbus",   mem_to_wb_bus,        71'(0));
        check_perf("rst_mid_perf");
        tick();
        reset = 1'b0;
        idle();
        exe_to_mem_valid = 1'b1;
        exe_to_mem_bus   = mk(1'b0, 1'b1, c_LD_W, 32'h0000_0400, 5'd6);
        tick();
        idle();
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h0BAD_F00D;
        #3;
        check("rst_after_valid", 71'(mem_to_wb_valid),      71'(1'b1));
        check("rst_after_final", 71'(mem_to_wb_bus[69:38]), 71'(32'h0BAD_F00D));
        tick();
        idle();
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'hFFFF_0000;
        #3;
        check("stray_valid",   71'(mem_to_wb_valid), 71'(1'b0));
        check("stray_allowin", 71'(mem_allowin),     71'(1'b1));
        tick();
        idle();
        exe_to_mem_valid = 1'b1;
        exe_to_mem_bus   = mk(1'b0, 1'b1, c_LD_HU, 32'h0000_0402, 5'd8);
        tick();
        idle();
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'hBEEF_0000;
        #3;
        check("post_stray_valid", 71'(mem_to_wb_valid),      71'(1'b1));
        check("post_stray_final", 71'(mem_to_wb_bus[69:38]), 71'(32'h0000_BEEF));
        tick();
        idle();
        #3;
        check_perf("final_perf");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
